// File: rtl/cuenta_regresiva_6b_if.sv
// Control and status bundle for the down-counter.
// The master drives the commands. The slave (the counter) drives the count and the status.
interface cuenta_regresiva_6b_if #(
  parameter int W = 6
);
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         reload_en;
  logic [W-1:0] Q;
  logic         busy;
  logic         paused;
  logic         tc;

  modport master (
    output load, load_val, start, stop, reload_en,
    input  Q, busy, paused, tc
  );

  modport slave (
    input  load, load_val, start, stop, reload_en,
    output Q, busy, paused, tc
  );
endinterface

// File: rtl/cuenta_regresiva_6b.sv
// W-bit down-counter with start/stop/pause and optional auto-reload.
// It counts from the loaded value down to 0. The tc pulse is registered and lasts one cycle.
module cuenta_regresiva_6b #(
  parameter int W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  cuenta_regresiva_6b_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t       state_r, state_n;
  logic [W-1:0] q_r, q_n;
  logic [W-1:0] rld_r, rld_n;
  logic         tc_r, tc_n;

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = '0;

  // State, count, reload value and tc register; reset clears everything asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      q_r     <= ZERO;
      rld_r   <= ZERO;
      tc_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      q_r     <= q_n;
      rld_r   <= rld_n;
      tc_r    <= tc_n;
    end
  end

  // Next-state logic. Priority is load, then stop, then start.
  // tc is low unless terminal count is reached.
  always_comb begin
    state_n = state_r;
    q_n     = q_r;
    rld_n   = rld_r;
    tc_n    = 1'b0;
    if (bus.load) begin
      q_n     = bus.load_val;
      rld_n   = bus.load_val;
      state_n = IDLE;
    end else begin
      unique case (state_r)
        IDLE: begin
          // stop is ignored here, so start+stop (which acts as stop) does nothing
          if (bus.start && !bus.stop && q_r != ZERO) state_n = RUN;
        end
        RUN: begin
          if (bus.stop) begin
            state_n = PAUSE;
          end else if (q_r > ONE) begin
            q_n = q_r - ONE;
          end else if (q_r == ONE) begin
            tc_n = 1'b1;
            if (bus.reload_en && rld_r != ZERO) begin
              q_n = rld_r;
            end else begin
              q_n     = ZERO;
              state_n = IDLE;
            end
          end else begin
            // A zero count in RUN is not reachable. Park in IDLE rather than wrap.
            state_n = IDLE;
          end
        end
        PAUSE: begin
          if (bus.start && !bus.stop) state_n = RUN;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.Q      = q_r;
  assign bus.busy   = (state_r == RUN);
  assign bus.paused = (state_r == PAUSE);
  assign bus.tc     = tc_r;

endmodule

// File: tb/tb_cuenta_regresiva_6b.sv
// Bench for cuenta_regresiva_6b.
// For each cycle the bench drives stimulus and pushes the expected outputs.
// After the edge it pops that entry and compares it with the DUT outputs.
module tb_cuenta_regresiva_6b;
  localparam int W = 6;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic         busy;
    logic         paused;
    logic         tc;
  } exp_t;

  exp_t sb[$];

  cuenta_regresiva_6b_if #(.W(W)) bus ();

  cuenta_regresiva_6b #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive the inputs at negedge, push the expectation, then compare just after posedge
  task automatic step(input string tag, input logic ld, input int val, input logic st,
                      input logic sp, input logic rel, input int eq, input logic eb,
                      input logic ep, input logic et);
    exp_t e;
    @(negedge clk);
    bus.load = ld; bus.load_val = W'(val); bus.start = st; bus.stop = sp; bus.reload_en = rel;
    e.tag = tag; e.q = W'(eq); e.busy = eb; e.paused = ep; e.tc = et;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".q"},      int'(bus.Q),      int'(e.q));
    chk({e.tag, ".busy"},   int'(bus.busy),   int'(e.busy));
    chk({e.tag, ".paused"}, int'(bus.paused), int'(e.paused));
    chk({e.tag, ".tc"},     int'(bus.tc),     int'(e.tc));
  endtask

  // Idle cycle: no commands, with the given reload_en
  task automatic nop(input string tag, input logic rel, input int eq, input logic eb,
                     input logic ep, input logic et);
    step(tag, 1'b0, 0, 1'b0, 1'b0, rel, eq, eb, ep, et);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load = 0; bus.load_val = '0; bus.start = 0; bus.stop = 0; bus.reload_en = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.q", int'(bus.Q), 0);
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.paused", int'(bus.paused), 0);
    chk("rst.tc", int'(bus.tc), 0);
    @(negedge clk) rst = 1'b0;

    // Start with no load after reset: Q is 0, so start is ignored
    step("rst_start", 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // One-shot from 5
    step("os_load", 1, 5, 0, 0, 0, 5, 0, 0, 0);
    step("os_start", 0, 0, 1, 0, 0, 5, 1, 0, 0);
    for (int v = 4; v >= 1; v--) nop("os_cnt", 0, v, 1, 0, 0);
    nop("os_tc", 0, 0, 0, 0, 1);
    nop("os_after", 0, 0, 0, 0, 0);

    // Auto-reload from 3: tc every third cycle and busy stays high
    step("ar_load", 1, 3, 0, 0, 1, 3, 0, 0, 0);
    step("ar_start", 0, 0, 1, 0, 1, 3, 1, 0, 0);
    for (int p = 0; p < 3; p++) begin
      nop("ar_2", 1, 2, 1, 0, 0);
      nop("ar_1", 1, 1, 1, 0, 0);
      nop("ar_rld", 1, 3, 1, 0, 1);
    end
    nop("ar_2b", 1, 2, 1, 0, 0);
    nop("ar_1b", 1, 1, 1, 0, 0);
    // A load at Q=1 takes priority over the reload, so there is no tc
    step("ar_ldtc", 1, 0, 0, 0, 1, 0, 0, 0, 0);

    // Pause and resume from 10
    step("pz_load", 1, 10, 0, 0, 0, 10, 0, 0, 0);
    step("pz_start", 0, 0, 1, 0, 0, 10, 1, 0, 0);
    for (int v = 9; v >= 7; v--) nop("pz_cnt", 0, v, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("pz_hold", 0, 0, 0, 1, 0, 7, 0, 1, 0);
    nop("pz_idle", 0, 7, 0, 1, 0);
    step("pz_resume", 0, 0, 1, 0, 0, 7, 1, 0, 0);
    for (int v = 6; v >= 1; v--) nop("pz_cnt2", 0, v, 1, 0, 0);
    nop("pz_tc", 0, 0, 0, 0, 1);
    nop("pz_after", 0, 0, 0, 0, 0);

    // Load 0 then start: stays IDLE with no tc
    step("z_load", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("z_start", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step("z_start2", 0, 0, 1, 0, 1, 0, 0, 0, 0);

    // Full range 63 down to 0 with no wrap
    step("max_load", 1, 63, 0, 0, 0, 63, 0, 0, 0);
    step("max_start", 0, 0, 1, 0, 0, 63, 1, 0, 0);
    for (int v = 62; v >= 1; v--) nop("max_cnt", 0, v, 1, 0, 0);
    nop("max_tc", 0, 0, 0, 0, 1);
    nop("max_nowrap", 0, 0, 0, 0, 0);
    step("max_start0", 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // start+stop at Q=1: the block goes to PAUSE with no tc
    step("ss_load", 1, 2, 0, 0, 0, 2, 0, 0, 0);
    step("ss_start", 0, 0, 1, 0, 0, 2, 1, 0, 0);
    nop("ss_1", 0, 1, 1, 0, 0);
    step("ss_both", 0, 0, 1, 1, 0, 1, 0, 1, 0);
    step("ss_both2", 0, 0, 1, 1, 0, 1, 0, 1, 0);
    step("ss_resume", 0, 0, 1, 0, 0, 1, 1, 0, 0);
    nop("ss_tc", 0, 0, 0, 0, 1);
    // In IDLE, start+stop acts as stop, which is ignored, so nothing happens
    step("ss_idle", 1, 4, 0, 0, 0, 4, 0, 0, 0);
    step("ss_idleboth", 0, 0, 1, 1, 0, 4, 0, 0, 0);

    // Load together with start while running: load wins and the block goes to IDLE
    step("pr_load", 1, 30, 0, 0, 0, 30, 0, 0, 0);
    step("pr_start", 0, 0, 1, 0, 0, 30, 1, 0, 0);
    nop("pr_29", 0, 29, 1, 0, 0);
    step("pr_ldst", 1, 20, 1, 0, 0, 20, 0, 0, 0);
    step("pr_start2", 0, 0, 1, 0, 0, 20, 1, 0, 0);
    step("pr_ldstop", 1, 8, 0, 1, 0, 8, 0, 0, 0);

    // Asynchronous reset in the middle of a count at Q=9
    step("rr_load", 1, 12, 0, 0, 0, 12, 0, 0, 0);
    step("rr_start", 0, 0, 1, 0, 0, 12, 1, 0, 0);
    for (int v = 11; v >= 9; v--) nop("rr_cnt", 0, v, 1, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rr_async.q", int'(bus.Q), 0);
    chk("rr_async.tc", int'(bus.tc), 0);
    chk("rr_async.busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    chk("rr_held.q", int'(bus.Q), 0);
    @(negedge clk) rst = 1'b0;
    step("rr_start2", 0, 0, 1, 0, 1, 0, 0, 0, 0);
    nop("rr_idle", 0, 0, 0, 0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
